// File: rtl/lcd_pkg.sv
// Shared LCD definitions for the panel write path and the sequencers that feed it.
//  - 9-bit word format {dc, byte}: bit8 selects command (0) or parameter/pixel data (1).
//  - RGB565 colour constants used by the clear/show-picture sequencers.
//  - Panel command opcodes for column/row address set and memory write.
package lcd_pkg;

  localparam logic        LCD_CMD = 1'b0;
  localparam logic        LCD_DAT = 1'b1;
  localparam int unsigned DC_BIT  = 8;

  localparam logic [15:0] RGB_WHITE = 16'hFFFF;
  localparam logic [15:0] RGB_BLACK = 16'h0000;
  localparam logic [15:0] RGB_RED   = 16'hF800;
  localparam logic [15:0] RGB_GREEN = 16'h07E0;
  localparam logic [15:0] RGB_BLUE  = 16'h001F;

  localparam logic [7:0] CMD_CASET = 8'h2A;
  localparam logic [7:0] CMD_RASET = 8'h2B;
  localparam logic [7:0] CMD_RAMWR = 8'h2C;

  function automatic logic [8:0] lcd_word(input logic dc, input logic [7:0] b);
    return {dc, b};
  endfunction

endpackage

// File: rtl/lcd_write.sv
// lcd_write: serialises one 9-bit LCD word {dc, byte} onto the panel's 4-wire SPI
// bus (mode 0, MSB first), then pulses wr_done for one cycle.
// Ports:
//  sys_clk   - system clock, rising edge
//  sys_rst_n - asynchronous active-low reset
//  data      - word to send, sampled only on accept
//  en_write  - level request, honoured only while idle
//  wr_done   - one-cycle pulse once the word is shifted and CS released
//  busy      - high from the accept edge until the post-word gap ends
//  lcd_cs    - chip select, active low
//  lcd_dc    - data/command select, updated only on accept
//  lcd_sclk  - SPI clock, idle low
//  lcd_mosi  - serial data, changes only on SCLK falling edges
module lcd_write
  import lcd_pkg::*;
#(
  parameter int unsigned SCK_HALF = 2,
  parameter int unsigned IDLE_GAP = 4
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic [8:0] data,
  input  logic       en_write,
  output logic       wr_done,
  output logic       busy,
  output logic       lcd_cs,
  output logic       lcd_dc,
  output logic       lcd_sclk,
  output logic       lcd_mosi
);

  localparam int unsigned CNT_MAX = (SCK_HALF > IDLE_GAP) ? SCK_HALF : IDLE_GAP;
  localparam int unsigned CW      = $clog2(CNT_MAX + 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(SCK_HALF - 1);
  localparam logic [CW-1:0] GAP_LAST  = CW'(IDLE_GAP - 1);

  typedef enum logic [5:0] {
    S_IDLE  = 6'b000001,
    S_SETUP = 6'b000010,
    S_SHIFT = 6'b000100,
    S_HOLD  = 6'b001000,
    S_DONE  = 6'b010000,
    S_GAP   = 6'b100000
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_q, bit_d;
  logic          ph_q, ph_d;
  logic [7:0]    shreg_q, shreg_d;
  logic          dc_q, dc_d;
  logic          cs_q, cs_d;
  logic          sclk_q, sclk_d;
  logic          mosi_q, mosi_d;
  logic          wr_done_q, wr_done_d;
  logic          busy_q, busy_d;
  logic          on_bus;

  // Next-state, counters and shift register.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    ph_d    = ph_q;
    shreg_d = shreg_q;
    dc_d    = dc_q;
    case (state_q)
      S_IDLE: begin
        if (en_write) begin
          shreg_d = data[7:0];
          dc_d    = data[DC_BIT];
          cnt_d   = '0;
          state_d = S_SETUP;
        end
      end
      S_SETUP: begin
        if (cnt_q == HALF_LAST) begin
          cnt_d   = '0;
          ph_d    = 1'b0;
          bit_d   = '0;
          state_d = S_SHIFT;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_SHIFT: begin
        if (cnt_q == HALF_LAST) begin
          cnt_d = '0;
          if (!ph_q) begin
            ph_d = 1'b1;
          end else begin
            // End of the high half: advance data on the falling edge.
            ph_d    = 1'b0;
            shreg_d = {shreg_q[6:0], 1'b0};
            bit_d   = bit_q + 3'd1;
            if (bit_q == 3'd7) state_d = S_HOLD;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_HOLD: begin
        if (cnt_q == HALF_LAST) begin
          cnt_d   = '0;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_DONE: begin
        cnt_d   = '0;
        state_d = S_GAP;
      end
      S_GAP: begin
        if (cnt_q == GAP_LAST) begin
          cnt_d   = '0;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Pin outputs are registered from the current state, so they trail the state
  // register by one cycle; this gives the 18*SCK_HALF+1 accept-to-wr_done latency.
  // busy is taken from the next state so it rises on the accept edge itself.
  always_comb begin
    on_bus    = (state_q == S_SETUP) || (state_q == S_SHIFT) || (state_q == S_HOLD);
    cs_d      = ~on_bus;
    sclk_d    = (state_q == S_SHIFT) && ph_q;
    mosi_d    = on_bus ? shreg_q[7] : 1'b0;
    wr_done_d = (state_q == S_DONE);
    busy_d    = (state_d != S_IDLE);
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      bit_q     <= '0;
      ph_q      <= 1'b0;
      shreg_q   <= '0;
      dc_q      <= 1'b0;
      cs_q      <= 1'b1;
      sclk_q    <= 1'b0;
      mosi_q    <= 1'b0;
      wr_done_q <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_q     <= bit_d;
      ph_q      <= ph_d;
      shreg_q   <= shreg_d;
      dc_q      <= dc_d;
      cs_q      <= cs_d;
      sclk_q    <= sclk_d;
      mosi_q    <= mosi_d;
      wr_done_q <= wr_done_d;
      busy_q    <= busy_d;
    end
  end

  assign wr_done  = wr_done_q;
  assign busy     = busy_q;
  assign lcd_cs   = cs_q;
  assign lcd_dc   = dc_q;
  assign lcd_sclk = sclk_q;
  assign lcd_mosi = mosi_q;

endmodule

// File: tb/tb_lcd_write.sv
// Bench for lcd_write: scoreboard of expected words, monitor reassembles the
// serial byte from SCLK rising edges and checks it against each wr_done.
module tb_lcd_write;

  localparam int unsigned H   = 2;
  localparam int unsigned G   = 4;
  localparam int unsigned LAT = 18 * H + 1;

  logic       sys_clk = 1'b0;
  logic       sys_rst_n = 1'b0;
  logic [8:0] data = '0;
  logic       en_write = 1'b0;
  logic       wr_done, busy, lcd_cs, lcd_dc, lcd_sclk, lcd_mosi;

  logic [8:0] data1 = '0;
  logic       en1 = 1'b0;
  logic       wr_done1, busy1, cs1, dc1, sclk1, mosi1;

  always #5 sys_clk = ~sys_clk;

  lcd_write #(.SCK_HALF(H), .IDLE_GAP(G)) u_dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .data(data), .en_write(en_write),
    .wr_done(wr_done), .busy(busy), .lcd_cs(lcd_cs), .lcd_dc(lcd_dc),
    .lcd_sclk(lcd_sclk), .lcd_mosi(lcd_mosi)
  );

  lcd_write #(.SCK_HALF(1), .IDLE_GAP(G)) u_dut1 (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .data(data1), .en_write(en1),
    .wr_done(wr_done1), .busy(busy1), .lcd_cs(cs1), .lcd_dc(dc1),
    .lcd_sclk(sclk1), .lcd_mosi(mosi1)
  );

  int n_checks = 0;
  int n_fail = 0;
  int n_push = 0;
  int n_done = 0;
  int unsigned cyc = 0;
  logic [8:0] exp_q[$];

  always @(posedge sys_clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Monitor: reassemble each word from the bus and compare on wr_done.
  logic        prev_sclk = 1'b0;
  logic        prev_busy = 1'b0;
  logic [7:0]  cap = '0;
  int          nrise = 0;
  logic        dc_seen = 1'b0;
  int unsigned acc_cyc = 0;
  logic [8:0]  expw;

  always @(negedge sys_clk) begin
    if (!sys_rst_n) begin
      prev_sclk = 1'b0;
      prev_busy = 1'b0;
      nrise     = 0;
      cap       = '0;
    end else begin
      if (busy && !prev_busy) acc_cyc = cyc;
      if (lcd_sclk && !prev_sclk) begin
        cap     = {cap[6:0], lcd_mosi};
        dc_seen = lcd_dc;
        nrise++;
      end
      if (wr_done) begin
        check("word_expected_at_done", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
          expw = exp_q.pop_front();
          check("shifted_byte", 32'(cap), 32'(expw[7:0]));
          check("dc_during_word", 32'(dc_seen), 32'(expw[8]));
          check("sclk_rises", 32'(nrise), 32'd8);
          check("accept_to_done", cyc - acc_cyc, LAT);
          check("cs_high_on_done", 32'(lcd_cs), 32'd1);
        end
        n_done++;
        nrise = 0;
      end
      prev_sclk = lcd_sclk;
      prev_busy = busy;
    end
  end

  task automatic wait_idle();
    int k = 0;
    do begin
      @(negedge sys_clk);
      k++;
    end while (busy && k < 200);
    check("idle_within_budget", 32'(busy), 32'd0);
  endtask

  task automatic send1(input logic [8:0] w);
    @(posedge sys_clk); #1;
    data = w;
    en_write = 1'b1;
    exp_q.push_back(w);
    n_push++;
    @(posedge sys_clk); #1;
    en_write = 1'b0;
    data = 9'($urandom);
    wait_idle();
  endtask

  // Inputs churn while the word is in flight; en_write is forced low before idle returns.
  task automatic send_noisy(input logic [8:0] w);
    @(posedge sys_clk); #1;
    data = w;
    en_write = 1'b1;
    exp_q.push_back(w);
    n_push++;
    @(posedge sys_clk); #1;
    for (int k = 0; k <= int'(18 * H + G); k++) begin
      data = 9'($urandom);
      en_write = 1'($urandom);
      @(posedge sys_clk); #1;
    end
    en_write = 1'b0;
    wait_idle();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int   k, r, ones, highs, lat;
    logic p, seen;

    // Reset held, then released with en_write low.
    repeat (3) @(posedge sys_clk);
    @(negedge sys_clk);
    check("reset_outputs_held", 32'({lcd_cs, lcd_dc, lcd_sclk, lcd_mosi, wr_done, busy}), 32'h20);
    #1 sys_rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge sys_clk);
      check("post_reset_idle", 32'({lcd_cs, lcd_dc, lcd_sclk, lcd_mosi, wr_done, busy}), 32'h20);
    end

    // Single command word.
    send1(9'h02A);

    // en_write held across two words; data changes one cycle after wr_done.
    @(posedge sys_clk); #1;
    data = 9'h1EF;
    en_write = 1'b1;
    exp_q.push_back(9'h1EF);
    n_push++;
    k = 0;
    do begin
      @(negedge sys_clk);
      k++;
    end while (!wr_done && k < 100);
    check("first_done_seen", 32'(wr_done), 32'd1);
    @(posedge sys_clk); #1;
    data = 9'h13F;
    exp_q.push_back(9'h13F);
    n_push++;
    repeat (G) @(negedge sys_clk);
    check("busy_low_before_reaccept", 32'(busy), 32'd0);
    @(negedge sys_clk);
    check("reaccept_gap", 32'(busy), 32'd1);
    en_write = 1'b0;
    wait_idle();

    // Randomised words, some with input churn mid-word.
    for (int i = 0; i < 12; i++) begin
      repeat ($urandom_range(0, 3)) @(posedge sys_clk);
      if ($urandom_range(0, 1) == 0) send1(9'($urandom));
      else send_noisy(9'($urandom));
    end

    // Async reset after the third SCLK rise aborts the word.
    @(posedge sys_clk); #1;
    data = 9'h155;
    en_write = 1'b1;
    @(posedge sys_clk); #1;
    en_write = 1'b0;
    r = 0;
    p = 1'b0;
    k = 0;
    while (r < 3 && k < 100) begin
      @(negedge sys_clk);
      if (lcd_sclk && !p) r++;
      p = lcd_sclk;
      k++;
    end
    check("third_rise_seen", 32'(r), 32'd3);
    #2 sys_rst_n = 1'b0;
    #1;
    check("async_reset_outputs", 32'({lcd_cs, lcd_dc, lcd_sclk, lcd_mosi, wr_done, busy}), 32'h20);
    seen = 1'b0;
    repeat (2) begin
      @(negedge sys_clk);
      if (wr_done) seen = 1'b1;
    end
    #1 sys_rst_n = 1'b1;
    repeat (60) begin
      @(negedge sys_clk);
      if (wr_done) seen = 1'b1;
    end
    check("no_done_after_abort", 32'(seen), 32'd0);
    send1(9'h0C3);

    // SCK_HALF=1 instance: SCLK toggles every cycle.
    @(posedge sys_clk); #1;
    data1 = 9'h1FF;
    en1 = 1'b1;
    @(negedge sys_clk);
    r = 0; ones = 0; highs = 0; lat = -1; p = 1'b0;
    for (int j = 1; j <= 40; j++) begin
      @(negedge sys_clk);
      en1 = 1'b0;
      if (sclk1 && !p) begin
        r++;
        if (mosi1) ones++;
      end
      if (sclk1) highs++;
      p = sclk1;
      if (wr_done1 && lat < 0) lat = j - 1;
    end
    check("h1_rises", 32'(r), 32'd8);
    check("h1_mosi_ones", 32'(ones), 32'd8);
    check("h1_sclk_high_cycles", 32'(highs), 32'd8);
    check("h1_latency", 32'(lat), 32'd19);
    check("h1_dc", 32'(dc1), 32'd1);

    repeat (5) @(negedge sys_clk);
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    check("done_count", 32'(n_done), 32'(n_push));

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
